// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream receive handshake and instruction-memory write port
//               shared by the loader (master) and its host/memory side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int instructionW = 32,
    parameter int addrW        = 16
);
    logic [7:0]              rxData;
    logic                    rxValid;
    logic                    rxReady;
    logic                    wrEn;
    logic [addrW-1:0]        wrAddr;
    logic [instructionW-1:0] wrData;

    modport master (
        input  rxData, rxValid,
        output rxReady, wrEn, wrAddr, wrData
    );

    modport slave (
        output rxData, rxValid,
        input  rxReady, wrEn, wrAddr, wrData
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction-memory writer. Assembles little-endian
//               32-bit words from a byte stream and writes consecutive words.
//               Optional trailing XOR checksum enabled by macro CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int               instructionW = 32,
    parameter int               addrW        = 16,
    parameter logic [addrW-1:0] BASE_ADDR    = '0
) (
    input  logic          sysCLK,
    input  logic          resetN,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
`ifdef CHECKSUM_EN
        S_CHK    = 3'd4,
`endif
        S_FIN    = 3'd5
    } state_t;

`ifdef CHECKSUM_EN
    localparam state_t c_TAIL = S_CHK;
`else
    localparam state_t c_TAIL = S_FIN;
`endif
    localparam logic [addrW-1:0] c_ADDR_ONE = {{(addrW-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_nextState;
    logic                    w_rxReady;
    logic                    w_xfer;
    logic [7:0]              r_lenLo;
    logic [15:0]             r_wordsLeft;
    logic [1:0]              r_byteIdx;
    logic                    r_wrEn;
    logic [addrW-1:0]        r_wrAddr;
    logic [instructionW-1:0] r_wrData;

    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_rxReady   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_nextState = S_LEN_LO;
            end
            S_LEN_LO: begin
                w_rxReady = 1'b1;
                busy      = 1'b1;
                if (bus.rxValid) w_nextState = S_LEN_HI;
            end
            S_LEN_HI: begin
                w_rxReady = 1'b1;
                busy      = 1'b1;
                if (bus.rxValid)
                    w_nextState = ({bus.rxData, r_lenLo} == 16'd0) ? c_TAIL : S_DATA;
            end
            S_DATA: begin
                w_rxReady = 1'b1;
                busy      = 1'b1;
                if (bus.rxValid && r_byteIdx == 2'd3 && r_wordsLeft == 16'd1)
                    w_nextState = c_TAIL;
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
                w_rxReady = 1'b1;
                busy      = 1'b1;
                if (bus.rxValid) w_nextState = S_FIN;
            end
`endif
            S_FIN: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    assign w_xfer = bus.rxValid & w_rxReady;

`ifdef CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_error;
`endif

    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) begin
            r_lenLo     <= '0;
            r_wordsLeft <= '0;
            r_byteIdx   <= '0;
            r_wrEn      <= 1'b0;
            r_wrAddr    <= '0;
            r_wrData    <= '0;
`ifdef CHECKSUM_EN
            r_csum      <= '0;
            r_error     <= 1'b0;
`endif
        end else begin
            r_wrEn <= 1'b0;
            // Address advances at the end of the write cycle so wrAddr is stable during wrEn.
            if (r_wrEn) r_wrAddr <= r_wrAddr + c_ADDR_ONE;
            if (r_state == S_IDLE && start) begin
                r_wrAddr  <= BASE_ADDR;
                r_byteIdx <= '0;
`ifdef CHECKSUM_EN
                r_csum    <= '0;
                r_error   <= 1'b0;
`endif
            end
            if (w_xfer) begin
                case (r_state)
                    S_LEN_LO: r_lenLo     <= bus.rxData;
                    S_LEN_HI: r_wordsLeft <= {bus.rxData, r_lenLo};
                    S_DATA: begin
                        r_wrData[{r_byteIdx, 3'b000} +: 8] <= bus.rxData;
                        r_byteIdx <= r_byteIdx + 2'd1;
`ifdef CHECKSUM_EN
                        r_csum    <= r_csum ^ bus.rxData;
`endif
                        if (r_byteIdx == 2'd3) begin
                            r_wrEn      <= 1'b1;
                            r_wordsLeft <= r_wordsLeft - 16'd1;
                        end
                    end
`ifdef CHECKSUM_EN
                    S_CHK: r_error <= (bus.rxData != r_csum);
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.rxReady = w_rxReady;
    assign bus.wrEn    = r_wrEn;
    assign bus.wrAddr  = r_wrAddr;
    assign bus.wrData  = r_wrData;
`ifdef CHECKSUM_EN
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Randomized self-checking bench; a base-0 and a base-0xFFFF
//               loader share one byte stream and are checked against a word model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    localparam int addrW = 16;

    logic sysCLK = 1'b0;
    logic resetN = 1'b0;
    logic start  = 1'b0;
    logic busy0, done0, error0, busy1, done1, error1;

    imem_loader_if #(.instructionW(32), .addrW(addrW)) bus0 ();
    imem_loader_if #(.instructionW(32), .addrW(addrW)) bus1 ();

    always #5 sysCLK = ~sysCLK;

    imem_loader #(.instructionW(32), .addrW(addrW), .BASE_ADDR(16'h0000)) dut0 (
        .sysCLK(sysCLK), .resetN(resetN), .start(start), .bus(bus0),
        .busy(busy0), .done(done0), .error(error0));
    imem_loader #(.instructionW(32), .addrW(addrW), .BASE_ADDR(16'hFFFF)) dut1 (
        .sysCLK(sysCLK), .resetN(resetN), .start(start), .bus(bus1),
        .busy(busy1), .done(done1), .error(error1));

    assign bus1.rxData  = bus0.rxData;
    assign bus1.rxValid = bus0.rxValid;

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         expQ0[$];
    wr_t         expQ1[$];
    logic [31:0] wq[$];

    // Every write strobe must match the next expected (address, word) pair.
    always @(negedge sysCLK) begin : mon
        wr_t e;
        if (bus0.wrEn === 1'b1) begin
            if (expQ0.size() == 0) check("unexpectedWrEn0", 1, 0);
            else begin
                e = expQ0.pop_front();
                check("wrAddr0", bus0.wrAddr, e.a);
                check("wrData0", bus0.wrData, e.d);
`ifdef CHECKSUM_EN
                if (expQ0.size() == 0) check("lastWrEnInChk", {busy0, bus0.rxReady}, 2'b11);
`else
                if (expQ0.size() == 0) check("lastWrEnInFin", done0, 1);
`endif
            end
        end
        if (bus1.wrEn === 1'b1) begin
            if (expQ1.size() == 0) check("unexpectedWrEn1", 1, 0);
            else begin
                e = expQ1.pop_front();
                check("wrAddr1", bus1.wrAddr, e.a);
                check("wrData1", bus1.wrData, e.d);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic sendByte(input logic [7:0] b, input int gapMax);
        int gap;
        bit acc;
        gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
        acc = 1'b0;
        repeat (gap) begin
            bus0.rxValid = 1'b0;
            bus0.rxData  = 8'($urandom());
            @(posedge sysCLK); #1;
        end
        bus0.rxValid = 1'b1;
        bus0.rxData  = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge sysCLK);
            acc = bus0.rxReady;
            @(posedge sysCLK); #1;
        end
        check("byteAccepted", acc, 1);
    endtask

    task automatic runLoad(input int gapMax, input bit badCsum, input bit pokeStart);
        logic [7:0] bytes[$];
        logic [7:0] cs;
        logic [15:0] n;
        logic [31:0] w;
        cs = 8'h00;
        n  = 16'(wq.size());
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        for (int i = 0; i < wq.size(); i++) begin
            w = wq[i];
            for (int k = 0; k < 4; k++) begin
                bytes.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
            expQ0.push_back('{a: 16'(i), d: w});
            expQ1.push_back('{a: 16'(32'hFFFF + i), d: w});
        end
`ifdef CHECKSUM_EN
        bytes.push_back(badCsum ? (cs ^ 8'($urandom_range(255, 1))) : cs);
`endif
        // A byte offered together with start must be refused.
        start        = 1'b1;
        bus0.rxValid = 1'b1;
        bus0.rxData  = bytes[0];
        @(negedge sysCLK);
        check("readyDuringStart", bus0.rxReady, 0);
        check("busyDuringStart", busy0, 0);
        @(posedge sysCLK); #1;
        start        = 1'b0;
        bus0.rxValid = 1'b0;
        @(negedge sysCLK);
        check("busyAfterStart", busy0, 1);
        check("errorClearedOnStart", error0, 0);
        @(posedge sysCLK); #1;
        for (int j = 0; j < bytes.size(); j++) begin
            if (pokeStart && j == 3) start = 1'b1;
            sendByte(bytes[j], gapMax);
            start = 1'b0;
        end
        bus0.rxValid = 1'b0;
        @(negedge sysCLK);
        check("doneAfterLastByte", done0, 1);
        check("doneAfterLastByte1", done1, 1);
        check("busyAtDone", busy0, 0);
        check("readyAtDone", bus0.rxReady, 0);
`ifdef CHECKSUM_EN
        check("errorAtDone", error0, badCsum);
`else
        check("errorAtDone", error0, 0);
`endif
        @(posedge sysCLK); #1;
        @(negedge sysCLK);
        check("donePulseWidth", done0, 0);
        check("idleNotReady", bus0.rxReady, 0);
        check("allWordsWritten0", expQ0.size(), 0);
        check("allWordsWritten1", expQ1.size(), 0);
`ifdef CHECKSUM_EN
        check("errorSticky", error0, badCsum);
`endif
        @(posedge sysCLK); #1;
    endtask

    task automatic loadTest1(input int gapMax);
        wq.delete();
        wq.push_back(32'h00000013);
        wq.push_back(32'h00100093);
        runLoad(gapMax, 1'b0, 1'b0);
    endtask

    initial begin
        int nw;
        bus0.rxValid = 1'b0;
        bus0.rxData  = 8'h00;
        repeat (2) @(posedge sysCLK);
        #1;
        check("rstWrEn", bus0.wrEn, 0);
        check("rstWrAddr0", bus0.wrAddr, 0);
        check("rstWrAddr1", bus1.wrAddr, 0);
        check("rstWrData", bus0.wrData, 0);
        check("rstBusy", busy0, 0);
        check("rstDone", done0, 0);
        check("rstError", error0, 0);
        check("rstReady", bus0.rxReady, 0);
        resetN = 1'b1;
        @(posedge sysCLK); #1;

        loadTest1(0);

        wq.delete();
        runLoad(0, 1'b0, 1'b0);

        loadTest1(5);

        // Abort a load with reset after two data bytes.
        start = 1'b1;
        @(posedge sysCLK); #1;
        start = 1'b0;
        sendByte(8'h02, 0);
        sendByte(8'h00, 0);
        sendByte(8'h13, 0);
        sendByte(8'h00, 0);
        bus0.rxValid = 1'b0;
        resetN = 1'b0;
        #1;
        check("midRstWrEn", bus0.wrEn, 0);
        check("midRstBusy", busy0, 0);
        check("midRstReady", bus0.rxReady, 0);
        check("midRstWrData", bus0.wrData, 0);
        @(posedge sysCLK); #1;
        resetN = 1'b1;
        repeat (4) @(posedge sysCLK);
        #1;
        loadTest1(0);

        for (int t = 0; t < 10; t++) begin
            nw = int'($urandom_range(6, 0));
            wq.delete();
            for (int i = 0; i < nw; i++) wq.push_back($urandom());
            runLoad(int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), nw >= 1);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
`default_nettype wire
